// File: rtl/exp_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : exp_pkg
//  Description : Shared constants for the exponent-unit result buffer.
//                Used by exp_result_fifo and exp_result_buffer.
//                Optional feature macro: EXP_RESULT_DROP_CNT_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
package exp_pkg;

    // Default result word width; matches the exponent unit's y output.
    localparam int EXP_WIDTH     = 16;

    // Default number of buffer entries.
    localparam int EXP_BUF_DEPTH = 4;

    // Width of the optional discarded-capture counter.
    localparam int DROP_CNT_W    = 8;

    // Increment that sticks at all-ones instead of wrapping to zero.
    function automatic logic [DROP_CNT_W-1:0] sat_inc(input logic [DROP_CNT_W-1:0] value);
        if (value == {DROP_CNT_W{1'b1}}) begin
            return value;
        end
        return value + DROP_CNT_W'(1);
    endfunction

endpackage : exp_pkg
`default_nettype wire

// File: rtl/exp_result_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : exp_result_fifo
//  Description : Circular word store with head/tail pointers and an occupancy
//                count. full and valid are derived from the count, so pointer
//                equality never has to be disambiguated. Entry contents are
//                intentionally not reset.
//  Revision    : 1.0 - initial release
// ============================================================================
module exp_result_fifo
    import exp_pkg::*;
#(
    parameter int WIDTH = EXP_WIDTH,
    parameter int DEPTH = EXP_BUF_DEPTH
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       clr,
    input  logic                       push,
    input  logic [WIDTH-1:0]           wdata,
    input  logic                       pop,
    output logic [WIDTH-1:0]           rdata,
    output logic                       valid,
    output logic                       full,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);

    localparam logic [CNT_W-1:0] c_depth = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] c_cnt_one = CNT_W'(1);
    localparam logic [PTR_W-1:0] c_ptr_one = PTR_W'(1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;

    logic w_wr;
    logic w_rd;

    // A read needs a stored word; a write needs room unless a read frees a slot this edge.
    assign w_rd = pop & (r_count != '0);
    assign w_wr = push & ((r_count != c_depth) | w_rd);

    assign rdata = r_mem[r_rd_ptr];
    assign valid = (r_count != '0);
    assign full  = (r_count == c_depth);
    assign count = r_count;

    // Storage write at the tail; flush wins so nothing is written during clr.
    always_ff @(posedge clk) begin
        if (w_wr && !clr) begin
            r_mem[r_wr_ptr] <= wdata;
        end
    end

    // Pointer and occupancy bookkeeping; DEPTH is a power of two so pointers wrap naturally.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (clr) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_wr) begin
                r_wr_ptr <= r_wr_ptr + c_ptr_one;
            end
            if (w_rd) begin
                r_rd_ptr <= r_rd_ptr + c_ptr_one;
            end
            case ({w_wr, w_rd})
                2'b10:   r_count <= r_count + c_cnt_one;
                2'b01:   r_count <= r_count - c_cnt_one;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule : exp_result_fifo
`default_nettype wire

// File: rtl/exp_result_buffer.sv
`default_nettype none
// ============================================================================
//  Module      : exp_result_buffer
//  Description : Captures the exponent unit's result on each rising edge of
//                its done level and queues it for a ready/valid consumer.
//                Captures arriving while full (with no simultaneous pop) are
//                dropped and flagged by a sticky overflow bit.
//                Optional feature macro: EXP_RESULT_DROP_CNT_EN adds an 8-bit
//                saturating count of dropped captures on port drop_cnt.
//  Revision    : 1.0 - initial release
// ============================================================================
module exp_result_buffer
    import exp_pkg::*;
#(
    parameter int WIDTH = EXP_WIDTH,
    parameter int DEPTH = EXP_BUF_DEPTH
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [WIDTH-1:0]           y_in,
    input  logic                       done_in,
    input  logic                       clr,
    input  logic                       out_ready,
    output logic [WIDTH-1:0]           out_data,
    output logic                       out_valid,
    output logic                       full,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       overflow
`ifdef EXP_RESULT_DROP_CNT_EN
    ,
    output logic [DROP_CNT_W-1:0]      drop_cnt
`endif
);

    logic r_done_q;
    logic r_armed;
    logic r_overflow;

    logic w_capture;
    logic w_pop;
    logic w_push;
    logic w_drop;

    // Rising edge of done_in only; r_armed blocks a capture on the first edge
    // after reset release when done_in was already high.
    assign w_capture = done_in & ~r_done_q & r_armed;
    assign w_pop     = out_valid & out_ready;
    // A pop in the same edge makes room, so a capture into a full buffer still lands.
    assign w_push    = w_capture & (~full | w_pop);
    assign w_drop    = w_capture & full & ~w_pop;

    assign overflow  = r_overflow;

    // Edge-detect history and post-reset arming; both keep running during clr.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_done_q <= 1'b0;
            r_armed  <= 1'b0;
        end else begin
            r_done_q <= done_in;
            r_armed  <= 1'b1;
        end
    end

    // Sticky drop indicator, cleared only by reset or flush.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_overflow <= 1'b0;
        end else if (clr) begin
            r_overflow <= 1'b0;
        end else if (w_drop) begin
            r_overflow <= 1'b1;
        end
    end

`ifdef EXP_RESULT_DROP_CNT_EN
    logic [DROP_CNT_W-1:0] r_drop_cnt;

    assign drop_cnt = r_drop_cnt;

    // Saturating count of discarded captures.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_drop_cnt <= '0;
        end else if (clr) begin
            r_drop_cnt <= '0;
        end else if (w_drop) begin
            r_drop_cnt <= sat_inc(r_drop_cnt);
        end
    end
`endif

    exp_result_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .clr   (clr),
        .push  (w_push),
        .wdata (y_in),
        .pop   (w_pop),
        .rdata (out_data),
        .valid (out_valid),
        .full  (full),
        .count (count)
    );

endmodule : exp_result_buffer
`default_nettype wire

// File: tb/tb_exp_result_buffer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_exp_result_buffer
//  Description : Self-checking bench for exp_result_buffer. Expected words are
//                queued when a capture is driven and compared as they are
//                popped. Build with EXP_RESULT_DROP_CNT_EN to cover drop_cnt.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_exp_result_buffer;

    localparam int WIDTH = 16;
    localparam int DEPTH = 4;

    logic             clk       = 1'b0;
    logic             rst       = 1'b0;
    logic [WIDTH-1:0] y_in      = '0;
    logic             done_in   = 1'b0;
    logic             clr       = 1'b0;
    logic             out_ready = 1'b0;
    logic [WIDTH-1:0] out_data;
    logic             out_valid;
    logic             full;
    logic [2:0]       count;
    logic             overflow;
`ifdef EXP_RESULT_DROP_CNT_EN
    logic [7:0]       drop_cnt;
`endif

    int n_checks = 0;
    int n_errors = 0;

    logic [WIDTH-1:0] exp_q[$];
    logic             m_ovf  = 1'b0;
    int               m_drop = 0;

    always #5 clk = ~clk;

    exp_result_buffer #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .y_in      (y_in),
        .done_in   (done_in),
        .clr       (clr),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .full      (full),
        .count     (count),
        .overflow  (overflow)
`ifdef EXP_RESULT_DROP_CNT_EN
        ,
        .drop_cnt  (drop_cnt)
`endif
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Reference behaviour of one capture event (after any same-edge pop was applied).
    task automatic model_capture(input logic [WIDTH-1:0] w);
        if (exp_q.size() < DEPTH) begin
            exp_q.push_back(w);
        end else begin
            m_ovf = 1'b1;
            if (m_drop < 255) m_drop++;
        end
    endtask

    // One done_in pulse: high for one edge, then low for one edge.
    task automatic pulse_done(input logic [WIDTH-1:0] w);
        y_in    = w;
        done_in = 1'b1;
        tick();
        model_capture(w);
        done_in = 1'b0;
        y_in    = ~w;
        tick();
    endtask

    task automatic test_reset;
        rst     = 1'b0;
        done_in = 1'b1;
        y_in    = 16'hAAAA;
        repeat (3) tick();
        n_checks++;
        if (count !== 3'd0 || out_valid !== 1'b0 || full !== 1'b0 || overflow !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_hold: count=%0d valid=%b full=%b ovf=%b, required 0 0 0 0", count, out_valid, full, overflow);
        end
`ifdef EXP_RESULT_DROP_CNT_EN
        n_checks++;
        if (drop_cnt !== 8'd0) begin
            n_errors++;
            $display("FAIL reset_drop_cnt: got %0d, required 0", drop_cnt);
        end
`endif
        rst = 1'b1;
        repeat (4) tick();
        n_checks++;
        if (count !== 3'd0 || out_valid !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_release_no_capture: count=%0d valid=%b, required 0 0", count, out_valid);
        end
        done_in = 1'b0;
        tick();
    endtask

    task automatic test_basic;
        out_ready = 1'b0;
        y_in      = 16'h0001;
        done_in   = 1'b1;
        tick();
        model_capture(16'h0001);
        n_checks++;
        if (out_valid !== 1'b1 || count !== 3'd1) begin
            n_errors++;
            $display("FAIL basic_latency: valid=%b count=%0d, required 1 1", out_valid, count);
        end
        done_in = 1'b0;
        tick();
        pulse_done(16'h0010);
        n_checks++;
        if (count !== 3'd2 || out_data !== 16'h0001) begin
            n_errors++;
            $display("FAIL basic_two_held: count=%0d data=%h, required 2 0001", count, out_data);
        end
        out_ready = 1'b1;
        for (int i = 0; i < 2; i++) begin
            n_checks++;
            if (out_valid !== 1'b1 || out_data !== exp_q[0]) begin
                n_errors++;
                $display("FAIL basic_pop%0d: valid=%b data=%h, required 1 %h", i, out_valid, out_data, exp_q[0]);
            end
            tick();
            void'(exp_q.pop_front());
        end
        out_ready = 1'b0;
        n_checks++;
        if (out_valid !== 1'b0 || count !== 3'd0) begin
            n_errors++;
            $display("FAIL basic_empty: valid=%b count=%0d, required 0 0", out_valid, count);
        end
    endtask

    task automatic test_overflow;
        for (int i = 0; i < DEPTH; i++) pulse_done(16'hA0A0 + 16'(i));
        n_checks++;
        if (count !== 3'd4 || full !== 1'b1 || overflow !== 1'b0) begin
            n_errors++;
            $display("FAIL ovf_filled: count=%0d full=%b ovf=%b, required 4 1 0", count, full, overflow);
        end
        pulse_done(16'hBEEF);
        n_checks++;
        if (count !== 3'(exp_q.size()) || overflow !== m_ovf || full !== 1'b1) begin
            n_errors++;
            $display("FAIL ovf_drop: count=%0d ovf=%b full=%b, required %0d %b 1", count, overflow, full, exp_q.size(), m_ovf);
        end
`ifdef EXP_RESULT_DROP_CNT_EN
        n_checks++;
        if (drop_cnt !== 8'(m_drop)) begin
            n_errors++;
            $display("FAIL ovf_drop_cnt: got %0d, required %0d", drop_cnt, m_drop);
        end
`endif
        out_ready = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            n_checks++;
            if (out_valid !== 1'b1 || out_data !== exp_q[0]) begin
                n_errors++;
                $display("FAIL ovf_drain%0d: valid=%b data=%h, required 1 %h", i, out_valid, out_data, exp_q[0]);
            end
            tick();
            void'(exp_q.pop_front());
        end
        out_ready = 1'b0;
        n_checks++;
        if (out_valid !== 1'b0 || overflow !== 1'b1) begin
            n_errors++;
            $display("FAIL ovf_lost_sticky: valid=%b ovf=%b, required 0 1", out_valid, overflow);
        end
        clr = 1'b1;
        tick();
        clr   = 1'b0;
        m_ovf = 1'b0;
        m_drop = 0;
        n_checks++;
        if (overflow !== 1'b0) begin
            n_errors++;
            $display("FAIL ovf_clr: ovf=%b, required 0", overflow);
        end
    endtask

    task automatic test_full_pop;
        for (int i = 0; i < DEPTH; i++) pulse_done(16'hC0C0 + 16'(i));
        y_in      = 16'hC4C4;
        done_in   = 1'b1;
        out_ready = 1'b1;
        n_checks++;
        if (full !== 1'b1 || out_data !== exp_q[0]) begin
            n_errors++;
            $display("FAIL fullpop_head: full=%b data=%h, required 1 %h", full, out_data, exp_q[0]);
        end
        tick();
        void'(exp_q.pop_front());
        model_capture(16'hC4C4);
        done_in   = 1'b0;
        out_ready = 1'b0;
        n_checks++;
        if (count !== 3'd4 || overflow !== 1'b0 || full !== 1'b1) begin
            n_errors++;
            $display("FAIL fullpop_state: count=%0d ovf=%b full=%b, required 4 0 1", count, overflow, full);
        end
        tick();
        out_ready = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            n_checks++;
            if (out_valid !== 1'b1 || out_data !== exp_q[0]) begin
                n_errors++;
                $display("FAIL fullpop_drain%0d: valid=%b data=%h, required 1 %h", i, out_valid, out_data, exp_q[0]);
            end
            tick();
            void'(exp_q.pop_front());
        end
        out_ready = 1'b0;
        n_checks++;
        if (out_valid !== 1'b0) begin
            n_errors++;
            $display("FAIL fullpop_empty: valid=%b, required 0", out_valid);
        end
    endtask

    task automatic test_hold;
        done_in = 1'b1;
        for (int i = 0; i < 10; i++) begin
            y_in = 16'h1234 + 16'(i);
            tick();
            if (i == 0) model_capture(16'h1234);
        end
        done_in = 1'b0;
        tick();
        n_checks++;
        if (count !== 3'd1 || out_data !== exp_q[0]) begin
            n_errors++;
            $display("FAIL hold_single: count=%0d data=%h, required 1 %h", count, out_data, exp_q[0]);
        end
        out_ready = 1'b1;
        tick();
        void'(exp_q.pop_front());
        out_ready = 1'b0;
    endtask

    task automatic test_back_to_back;
        pulse_done(16'h5000);
        pulse_done(16'h5001);
        for (int i = 2; i < 14; i++) begin
            y_in      = 16'h5000 + 16'(i);
            done_in   = 1'b1;
            out_ready = 1'b1;
            n_checks++;
            if (out_valid !== 1'b1 || out_data !== exp_q[0]) begin
                n_errors++;
                $display("FAIL b2b_head%0d: valid=%b data=%h, required 1 %h", i, out_valid, out_data, exp_q[0]);
            end
            tick();
            void'(exp_q.pop_front());
            model_capture(16'h5000 + 16'(i));
            done_in   = 1'b0;
            out_ready = 1'b0;
            n_checks++;
            if (count !== 3'(exp_q.size())) begin
                n_errors++;
                $display("FAIL b2b_count%0d: got %0d, required %0d", i, count, exp_q.size());
            end
            tick();
        end
        out_ready = 1'b1;
        while (exp_q.size() > 0) begin
            n_checks++;
            if (out_valid !== 1'b1 || out_data !== exp_q[0]) begin
                n_errors++;
                $display("FAIL b2b_drain: valid=%b data=%h, required 1 %h", out_valid, out_data, exp_q[0]);
            end
            tick();
            void'(exp_q.pop_front());
        end
        out_ready = 1'b0;
    endtask

    task automatic test_clr;
        for (int i = 0; i < DEPTH + 1; i++) pulse_done(16'hD0D0 + 16'(i));
        out_ready = 1'b1;
        repeat (2) begin
            tick();
            void'(exp_q.pop_front());
        end
        out_ready = 1'b0;
        n_checks++;
        if (count !== 3'd2 || overflow !== 1'b1) begin
            n_errors++;
            $display("FAIL clr_pre: count=%0d ovf=%b, required 2 1", count, overflow);
        end
        clr     = 1'b1;
        done_in = 1'b1;
        y_in    = 16'hEEEE;
        tick();
        exp_q.delete();
        m_ovf   = 1'b0;
        m_drop  = 0;
        clr     = 1'b0;
        done_in = 1'b0;
        n_checks++;
        if (count !== 3'd0 || overflow !== 1'b0 || out_valid !== 1'b0) begin
            n_errors++;
            $display("FAIL clr_flush: count=%0d ovf=%b valid=%b, required 0 0 0", count, overflow, out_valid);
        end
`ifdef EXP_RESULT_DROP_CNT_EN
        n_checks++;
        if (drop_cnt !== 8'(m_drop)) begin
            n_errors++;
            $display("FAIL clr_drop_cnt: got %0d, required %0d", drop_cnt, m_drop);
        end
`endif
        tick();
    endtask

    task automatic test_reset_mid;
        pulse_done(16'h7001);
        pulse_done(16'h7002);
        rst = 1'b0;
        #2;
        exp_q.delete();
        n_checks++;
        if (count !== 3'd0 || out_valid !== 1'b0) begin
            n_errors++;
            $display("FAIL rstmid_async: count=%0d valid=%b, required 0 0", count, out_valid);
        end
        tick();
        rst = 1'b1;
        tick();
        out_ready = 1'b1;
        repeat (2) tick();
        out_ready = 1'b0;
        n_checks++;
        if (count !== 3'd0 || out_valid !== 1'b0) begin
            n_errors++;
            $display("FAIL empty_pop_noeffect: count=%0d valid=%b, required 0 0", count, out_valid);
        end
        pulse_done(16'h7777);
        n_checks++;
        if (count !== 3'd1 || out_data !== exp_q[0]) begin
            n_errors++;
            $display("FAIL rstmid_after: count=%0d data=%h, required 1 %h", count, out_data, exp_q[0]);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_basic();
        test_overflow();
        test_full_pop();
        test_hold();
        test_back_to_back();
        test_clr();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule : tb_exp_result_buffer
`default_nettype wire

// File: doc/exp_result_buffer.md
EXP_RESULT_BUFFER -- requirements
Module: exp_result_buffer

Interface
REQ-001 The module SHALL have parameter WIDTH, default 16, meaning the result word width (matches the exponent unit's y).
REQ-002 The module SHALL have parameter DEPTH, default 4, meaning the number of buffer entries (power of two, 2..16).
REQ-003 The module SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 The module SHALL have port rst, input, 1 bit: asynchronous, active-low reset.
REQ-005 The module SHALL have port y_in, input, WIDTH bits: the result word from the exponent unit.
REQ-006 The module SHALL have port done_in, input, 1 bit: the exponent unit's ready level.
REQ-007 The module SHALL have port clr, input, 1 bit: synchronous flush.
REQ-008 The module SHALL have port out_ready, input, 1 bit: the consumer accepts the head word.
REQ-009 The module SHALL have port out_data, output, WIDTH bits: the head entry.
REQ-010 The module SHALL have port out_valid, output, 1 bit: the buffer is non-empty.
REQ-011 The module SHALL have port full, output, 1 bit: count == DEPTH.
REQ-012 The module SHALL have port count, output, clog2(DEPTH+1) bits: number of stored entries.
REQ-013 The module SHALL have port overflow, output, 1 bit: sticky flag, set when a result was dropped.

Function
REQ-014 The module SHALL register done_in into done_q each cycle; a capture event SHALL be done_in=1 and done_q=0 (rising edge only).
- A held-high done_in SHALL produce exactly one capture.
REQ-015 On a capture event with the buffer not full, the module SHALL write y_in into the tail entry at that edge and advance the tail pointer.
REQ-016 A pop SHALL occur when out_valid=1 and out_ready=1; the head pointer SHALL advance at that edge.
REQ-017 out_data SHALL be driven combinationally from the head entry; it is don't-care while out_valid=0.
REQ-018 Latency: for a capture sampled at edge k into an empty buffer, out_valid SHALL be 1 after edge k (one-cycle minimum); there is no same-cycle bypass.
REQ-019 When capture and pop occur together and the buffer is full, the module SHALL perform both, with no drop, and count unchanged.
REQ-020 When capture and pop occur together and the buffer is neither full nor empty, count SHALL be unchanged and both pointers SHALL advance.
REQ-021 On a capture event while full with no pop, the word SHALL be discarded and overflow SHALL be set.
REQ-022 Pointers SHALL wrap modulo DEPTH.
- full SHALL be derived from count, not from pointer equality.
REQ-023 clr=1 SHALL take priority over capture and pop: pointers and count go to 0 and overflow is cleared; done_q still updates.
REQ-024 out_ready while empty SHALL have no effect.

Reset
REQ-025 While rst=0 the module SHALL hold: pointers=0, count=0, done_q=0, overflow=0, out_valid=0, full=0.
- Entry contents are not reset.
REQ-026 If done_in is high when rst releases, no capture SHALL occur until done_in falls and rises again (done_q is reset to 0, and capture is gated for the first cycle after release).
REQ-027 A reset mid-operation SHALL discard all buffered words.

Configuration
REQ-028 With EXP_RESULT_DROP_CNT_EN defined, the module SHALL add output drop_cnt (8 bits, reset 0, cleared by clr), incremented on each discarded capture and saturating at 255.
- Without the macro, the port and counter SHALL be absent; overflow remains.

Structure
REQ-029 A shared package exp_pkg SHALL hold EXP_WIDTH=16, EXP_BUF_DEPTH=4 and DROP_CNT_W=8.
REQ-030 Storage, pointers and count SHALL live in one sub-module, exp_result_fifo.
- Edge detect, drop logic and the counter SHALL stay in the top.

Verification
REQ-031 Reset with done_in=1 throughout, then release -> no capture, count=0, out_valid=0.
REQ-032 Pulse done_in with y_in=16'h0001, then 16'h0010, with out_ready=0 -> count=2, out_data=16'h0001; raise out_ready for 2 cycles -> 16'h0001, then 16'h0010, then out_valid=0.
REQ-033 Fill with 4 words, then a 5th done_in rising edge with out_ready=0 -> count=4, overflow=1, the 5th word lost, drop_cnt=1 (macro on).
REQ-034 Full buffer, with a 5th rising edge in the same cycle as a pop -> count stays 4, overflow=0, and the 5th word is read last.
REQ-035 Hold done_in high for 10 cycles -> exactly one entry is written.
REQ-036 Two words buffered, overflow=1, assert clr with a simultaneous done_in rising edge -> count=0, overflow=0, drop_cnt=0.
- Repeat pushes past 8 to exercise pointer wrap.
